action_selector: RTL and testbench

- Reader-side companion to the 64x16 action RAM.
- On request, it reads the four Q-values for one state, one per action, and selects the greedy (argmax) action.
- With a programmable probability, the greedy choice is overridden by a pseudo-random action (epsilon-greedy).
- It sits between the agent controller and the RAM read port; it never writes the RAM.

---
 rtl/rl_pkg.sv | 21 ++
 rtl/action_selector_lfsr8.sv | 25 ++
 rtl/action_selector.sv | 132 +++++++++++++
 tb/tb_action_selector.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rl_pkg.sv
// Shared types and sizes for the Q-learning datapath blocks.
package rl_pkg;

  localparam int STATE_W = 4;
  localparam int ACT_W   = 2;
  localparam int Q_W     = 16;
  localparam int ADDR_W  = STATE_W + ACT_W;

  typedef logic [STATE_W-1:0]     state_t;
  typedef logic [ACT_W-1:0]       action_t;
  typedef logic signed [Q_W-1:0]  q_t;
  typedef logic [ADDR_W-1:0]      addr_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    WAIT   = 2'd2,
    DECIDE = 2'd3
  } sel_fsm_t;

endpackage

// File: rtl/action_selector_lfsr8.sv
// 8-bit Galois LFSR, polynomial x^8+x^6+x^5+x^4+1, free running.
module lfsr8 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] seed,
  output logic [7:0] out
);

  logic [7:0] seed_eff;

  // An all-zero seed would lock the register, so it is replaced by 1.
  always_comb begin
    seed_eff = (seed == '0) ? 8'h01 : seed;
  end

  // Right-shifting Galois step; taps 8,6,5,4 map to mask bits 7,5,4,3.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out <= seed_eff;
    end else begin
      out <= {1'b0, out[7:1]} ^ (out[0] ? 8'hB8 : 8'h00);
    end
  end

endmodule

// File: rtl/action_selector.sv
// Epsilon-greedy action selector: reads four Q-values for a state from
// the action RAM, picks the signed argmax, optionally overrides it with
// a pseudo-random action.
module action_selector #(
  parameter int         STATE_W    = rl_pkg::STATE_W,
  parameter int         ACT_W      = rl_pkg::ACT_W,
  parameter int         Q_W        = rl_pkg::Q_W,
  parameter logic [7:0] EPS_THRESH = 8'd0,
  parameter logic [7:0] LFSR_SEED  = 8'hA5
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [STATE_W-1:0]       state_in,
  output logic                     busy,
  output logic                     done,
  output logic [ACT_W-1:0]         action_out,
  output logic [Q_W-1:0]           q_out,
  output logic                     explored,
  output logic                     ram_en,
  output logic [STATE_W+ACT_W-1:0] ram_rd_addr,
  input  logic [Q_W-1:0]           ram_data
);

  import rl_pkg::*;

  localparam int unsigned N_ACT = 1 << ACT_W;

  sel_fsm_t                fsm;
  logic [STATE_W-1:0]      st_r;
  logic [ACT_W-1:0]        a;
  logic                    cap_v;
  logic [ACT_W-1:0]        cap_k;
  logic signed [Q_W-1:0]   q_r [N_ACT];
  logic signed [Q_W-1:0]   max_q;
  logic [ACT_W-1:0]        max_a;
  logic signed [Q_W-1:0]   rd_s;
  logic [7:0]              lfsr;
  logic [7:0]              lfsr_snap;

  lfsr8 u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .seed  (LFSR_SEED),
    .out   (lfsr)
  );

  // RAM read port: enabled while addresses are issued and the last read lands.
  always_comb begin
    ram_en      = (fsm == ISSUE) || (fsm == WAIT);
    ram_rd_addr = {st_r, a};
    rd_s        = ram_data;
  end

  // Request sequencing and registered result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm        <= IDLE;
      st_r       <= '0;
      a          <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      action_out <= '0;
      q_out      <= '0;
      explored   <= 1'b0;
      lfsr_snap  <= '0;
    end else begin
      done <= 1'b0;
      case (fsm)
        IDLE: begin
          if (start) begin
            st_r <= state_in;
            a    <= '0;
            busy <= 1'b1;
            fsm  <= ISSUE;
          end
        end
        ISSUE: begin
          if (a == '1) begin
            fsm <= WAIT;
          end else begin
            a <= a + 1'b1;
          end
        end
        WAIT: begin
          lfsr_snap <= lfsr;
          fsm       <= DECIDE;
        end
        DECIDE: begin
          if (lfsr_snap < EPS_THRESH) begin
            action_out <= lfsr_snap[ACT_W-1:0];
            q_out      <= q_r[lfsr_snap[ACT_W-1:0]];
            explored   <= 1'b1;
          end else begin
            action_out <= max_a;
            q_out      <= max_q;
            explored   <= 1'b0;
          end
          done <= 1'b1;
          busy <= 1'b0;
          fsm  <= IDLE;
        end
        default: fsm <= IDLE;
      endcase
    end
  end

  // Read data trails its address by one edge; cap_k tracks which action it
  // belongs to. Strict greater-than keeps the lowest index on ties.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_v <= 1'b0;
      cap_k <= '0;
      max_q <= '0;
      max_a <= '0;
      for (int unsigned i = 0; i < N_ACT; i++) begin
        q_r[i] <= '0;
      end
    end else begin
      cap_v <= (fsm == ISSUE);
      cap_k <= a;
      if (cap_v) begin
        q_r[cap_k] <= rd_s;
        if ((cap_k == '0) || (rd_s > max_q)) begin
          max_q <= rd_s;
          max_a <= cap_k;
        end
      end
    end
  end

endmodule

// File: tb/tb_action_selector.sv
// Directed bench for action_selector: a greedy instance and a forced-explore
// instance share stimulus; each has its own RAM model, LFSR model and
// expected-result queue.
module tb_action_selector;

  typedef struct packed {
    logic [1:0]  act;
    logic [15:0] q;
    logic        ex;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [3:0]  state_in;
  logic [15:0] mem [64];

  int errors = 0;
  int checks = 0;

  exp_t q0[$];
  exp_t q1[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] step(input logic [7:0] v);
    step = {1'b0, v[7:1]} ^ (v[0] ? 8'b1011_1000 : 8'h00);
  endfunction

  for (genvar g = 0; g < 2; g++) begin : inst
    localparam logic [7:0] EPS  = (g == 0) ? 8'd0  : 8'd255;
    localparam logic [7:0] SEED = (g == 0) ? 8'hA5 : 8'h03;

    logic        busy, done, explored, ram_en;
    logic [1:0]  action_out;
    logic [15:0] q_out, rd;
    logic [5:0]  ram_rd_addr;
    logic [7:0]  lm;

    action_selector #(.EPS_THRESH(EPS), .LFSR_SEED(SEED)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .state_in    (state_in),
      .busy        (busy),
      .done        (done),
      .action_out  (action_out),
      .q_out       (q_out),
      .explored    (explored),
      .ram_en      (ram_en),
      .ram_rd_addr (ram_rd_addr),
      .ram_data    (rd)
    );

    always @(posedge clk) rd <= ram_en ? mem[ram_rd_addr] : 16'h0000;

    always @(posedge clk or negedge rst_n) begin
      if (!rst_n) lm <= (SEED == 8'h00) ? 8'h01 : SEED;
      else        lm <= step(lm);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // m is the LFSR value that will be sampled at E0; the decision uses E5's.
  function automatic exp_t model(input logic [7:0] eps, input logic [3:0] s, input logic [7:0] m);
    exp_t        r;
    logic [7:0]  v;
    logic [1:0]  kk;
    logic [1:0]  best;
    logic [15:0] bq;
    v = m;
    for (int i = 0; i < 5; i++) v = step(v);
    best = 2'd0;
    bq   = mem[{s, 2'd0}];
    for (int k = 1; k < 4; k++) begin
      kk = k[1:0];
      if ($signed(mem[{s, kk}]) > $signed(bq)) begin
        best = kk;
        bq   = mem[{s, kk}];
      end
    end
    if (v < eps) begin
      r.act = v[1:0];
      r.q   = mem[{s, v[1:0]}];
      r.ex  = 1'b1;
    end else begin
      r.act = best;
      r.q   = bq;
      r.ex  = 1'b0;
    end
    return r;
  endfunction

  // Scoreboard side: every done pulse must match the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (inst[0].done) begin
      check("spurious_done0", (q0.size() != 0), 1);
      if (q0.size() != 0) begin
        e = q0.pop_front();
        check("sb_act0", inst[0].action_out, e.act);
        check("sb_q0",   inst[0].q_out,      e.q);
        check("sb_ex0",  inst[0].explored,   e.ex);
      end
    end
    if (inst[1].done) begin
      check("spurious_done1", (q1.size() != 0), 1);
      if (q1.size() != 0) begin
        e = q1.pop_front();
        check("sb_act1", inst[1].action_out, e.act);
        check("sb_q1",   inst[1].q_out,      e.q);
        check("sb_ex1",  inst[1].explored,   e.ex);
      end
    end
  end

  // Called at a negedge; returns at the negedge after E0.
  task automatic issue(input logic [3:0] s);
    start    = 1'b1;
    state_in = s;
    q0.push_back(model(8'd0,   s, inst[0].lm));
    q1.push_back(model(8'd255, s, inst[1].lm));
    @(negedge clk);
    start    = 1'b0;
    state_in = ~s;
  endtask

  // Walks E1..E6 from the negedge after E0; ends in the done cycle.
  task automatic follow(input logic [3:0] s, input bit inject,
                        input logic [1:0] xa, input logic [15:0] xq);
    check("busy_e0", inst[0].busy, 1);
    check("en_e0",   inst[0].ram_en, 1);
    check("addr_e0", inst[0].ram_rd_addr, {s, 2'd0});
    for (int k = 1; k < 4; k++) begin
      @(negedge clk);
      if (inject && k == 2) begin
        start    = 1'b1;
        state_in = s ^ 4'hA;
      end else begin
        start = 1'b0;
      end
      check("en_issue", inst[0].ram_en, 1);
      check("addr_issue", inst[0].ram_rd_addr, {s, k[1:0]});
    end
    @(negedge clk);
    start = 1'b0;
    check("en_wait",   inst[0].ram_en, 1);
    check("busy_wait", inst[0].busy, 1);
    @(negedge clk);
    check("en_decide",   inst[0].ram_en, 0);
    check("busy_decide", inst[0].busy, 1);
    check("done_early",  inst[0].done, 0);
    @(negedge clk);
    check("done_e6",  inst[0].done, 1);
    check("done1_e6", inst[1].done, 1);
    check("busy_e6",  inst[0].busy, 0);
    check("en_e6",    inst[0].ram_en, 0);
    check("act",      inst[0].action_out, xa);
    check("qval",     inst[0].q_out, xq);
    check("explored0", inst[0].explored, 0);
  endtask

  task automatic gap(input logic [1:0] xa);
    @(negedge clk);
    check("done_gap", inst[0].done, 0);
    check("en_gap",   inst[0].ram_en, 0);
    check("hold_act", inst[0].action_out, xa);
  endtask

  initial begin
    rst_n    = 1'b0;
    start    = 1'b0;
    state_in = 4'd0;
    for (int i = 0; i < 64; i++) mem[i] = 16'(i * 16'h0101);
    mem[20] = 16'h0010; mem[21] = 16'h0050; mem[22] = 16'h0030; mem[23] = 16'h0040;
    mem[0]  = 16'hFFF0; mem[1]  = 16'h0007; mem[2]  = 16'h0007; mem[3]  = 16'h8000;
    mem[60] = 16'h8001; mem[61] = 16'h0100; mem[62] = 16'h7FFF; mem[63] = 16'h7FFF;

    repeat (2) @(negedge clk);
    check("rst_busy",  inst[0].busy, 0);
    check("rst_done",  inst[0].done, 0);
    check("rst_exp",   inst[0].explored, 0);
    check("rst_en",    inst[0].ram_en, 0);
    check("rst_act",   inst[0].action_out, 0);
    check("rst_q",     inst[0].q_out, 0);
    check("rst_addr",  inst[0].ram_rd_addr, 0);
    check("rst_en1",   inst[1].ram_en, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Greedy pick: state 5
    issue(4'd5);
    follow(4'd5, 1'b0, 2'd1, 16'h0050);
    gap(2'd1);

    // Tie and negatives: state 0
    issue(4'd0);
    follow(4'd0, 1'b0, 2'd1, 16'h0007);
    gap(2'd1);

    // Start while busy is ignored; next start on the done cycle is taken
    issue(4'd5);
    follow(4'd5, 1'b1, 2'd1, 16'h0050);
    issue(4'd0);
    follow(4'd0, 1'b0, 2'd1, 16'h0007);
    gap(2'd1);

    // Reset at E3 of a request aborts it
    issue(4'd5);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    q0.delete();
    q1.delete();
    #1;
    check("abort_busy", inst[0].busy, 0);
    check("abort_en",   inst[0].ram_en, 0);
    check("abort_done", inst[0].done, 0);
    check("abort_act",  inst[0].action_out, 0);
    check("abort_q",    inst[0].q_out, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("abort_nodone", inst[0].done | inst[1].done, 0);
    end
    rst_n = 1'b1;
    @(negedge clk);

    // Top state: addresses 60..63, no wrap
    issue(4'd15);
    follow(4'd15, 1'b0, 2'd2, 16'h7FFF);
    gap(2'd2);
    gap(2'd2);

    check("drained0", q0.size(), 0);
    check("drained1", q1.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
